game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 158 +++++++++++++++
 tb/tb_game_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game flow sequencer: MENU -> COUNTDOWN -> PLAY -> RESULT -> MENU.
// Mode is chosen with LEFT/RIGHT in MENU and the game is started with SELECT.
// Optional pause support is compiled in when GAME_SEQ_PAUSE_EN is defined.
module game_sequencer #(
    parameter int unsigned COUNT_SECS = 3,
    parameter int unsigned PLAY_SECS  = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] key_code,
    input  logic       key_press,
    input  logic       tick_1s,
    input  logic       song_done,
    output logic [1:0] mode_sel,
    output logic       lcd_state,
    output logic       game_run,
    output logic       game_clear,
    output logic [3:0] countdown,
    output logic [2:0] seq_state
);

    localparam logic [4:0] KEY_LEFT   = 5'b00100;
    localparam logic [4:0] KEY_RIGHT  = 5'b00110;
    localparam logic [4:0] KEY_SELECT = 5'b00101;
`ifdef GAME_SEQ_PAUSE_EN
    localparam logic [4:0] KEY_PAUSE  = 5'b00000;
`endif

    localparam logic [3:0] COUNT_LOAD = 4'(COUNT_SECS);
    localparam logic [7:0] PLAY_LAST  = 8'(PLAY_SECS - 1);

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_RESULT    = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       key_prev;
    logic       key_armed;
    logic       key_event;
    logic [7:0] play_timer;
    logic [7:0] timer_next;
    logic [1:0] mode_next;
    logic [3:0] count_next;
    logic       clear_next;

    // key_armed stays low until key_press has been seen released after reset,
    // so a key held across reset release never yields an event.
    assign key_event = key_press & ~key_prev & key_armed;
    assign seq_state = state;

    // Key edge detector: previous key_press level and post-reset arming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_prev  <= 1'b0;
            key_armed <= 1'b0;
        end else begin
            key_prev <= key_press;
            if (!key_press) begin
                key_armed <= 1'b1;
            end
        end
    end

    // State register plus registered outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_MENU;
            mode_sel   <= '0;
            countdown  <= '0;
            play_timer <= '0;
            lcd_state  <= 1'b0;
            game_run   <= 1'b0;
            game_clear <= 1'b0;
        end else begin
            state      <= state_next;
            mode_sel   <= mode_next;
            countdown  <= count_next;
            play_timer <= timer_next;
            lcd_state  <= (state_next != S_MENU);
            game_run   <= (state_next == S_PLAY);
            game_clear <= clear_next;
        end
    end

    // Next-state, mode, countdown and play-timer logic.
    always_comb begin
        state_next = state;
        mode_next  = mode_sel;
        count_next = countdown;
        timer_next = play_timer;
        clear_next = 1'b0;
        case (state)
            S_MENU: begin
                if (key_event) begin
                    if (key_code == KEY_RIGHT) begin
                        mode_next = (mode_sel == 2'd3) ? 2'd1 : mode_sel + 2'd1;
                    end else if (key_code == KEY_LEFT) begin
                        mode_next = (mode_sel <= 2'd1) ? 2'd3 : mode_sel - 2'd1;
                    end else if (key_code == KEY_SELECT && mode_sel != 2'd0) begin
                        state_next = S_COUNTDOWN;
                        count_next = COUNT_LOAD;
                        clear_next = 1'b1;
                    end
                end
            end
            S_COUNTDOWN: begin
                // The tick that reaches zero is shown for one cycle before PLAY.
                if (countdown == 4'd0) begin
                    state_next = S_PLAY;
                    timer_next = '0;
                end else if (tick_1s) begin
                    count_next = countdown - 4'd1;
                end
            end
            S_PLAY: begin
                if (tick_1s) begin
                    timer_next = play_timer + 8'd1;
                end
                if (song_done || (tick_1s && play_timer == PLAY_LAST)) begin
                    state_next = S_RESULT;
                end
`ifdef GAME_SEQ_PAUSE_EN
                else if (key_event && key_code == KEY_PAUSE) begin
                    state_next = S_PAUSE;
                end
`endif
            end
`ifdef GAME_SEQ_PAUSE_EN
            S_PAUSE: begin
                if (key_event) begin
                    if (key_code == KEY_PAUSE) begin
                        state_next = S_PLAY;
                    end else if (key_code == KEY_SELECT) begin
                        state_next = S_RESULT;
                    end
                end
            end
`endif
            S_RESULT: begin
                if (key_event && key_code == KEY_SELECT) begin
                    state_next = S_MENU;
                end
            end
            default: begin
                state_next = S_MENU;
            end
        endcase
        if (state_next != S_COUNTDOWN) begin
            count_next = '0;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer; covers the pause build when
// GAME_SEQ_PAUSE_EN is defined, the plain build otherwise.
module tb_game_sequencer;

    localparam logic [4:0] K_L = 5'b00100;
    localparam logic [4:0] K_R = 5'b00110;
    localparam logic [4:0] K_S = 5'b00101;
    localparam logic [4:0] K_P = 5'b00000;
    localparam logic [4:0] K_X = 5'b11111;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] key_code;
    logic       key_press;
    logic       tick_1s;
    logic       song_done;
    logic [1:0] mode_sel;
    logic       lcd_state;
    logic       game_run;
    logic       game_clear;
    logic [3:0] countdown;
    logic [2:0] seq_state;
    logic [11:0] act;

    // act = {seq_state, mode_sel, countdown, game_run, lcd_state, game_clear}
    assign act = {seq_state, mode_sel, countdown, game_run, lcd_state, game_clear};

    typedef struct {
        string       name;
        logic [4:0]  code;
        logic        press;
        logic        tick;
        logic        done;
        logic        rst;
        logic [11:0] vec;
    } step_t;

    step_t plan[$];
    step_t sb[$];
    int    checks = 0;
    int    errors = 0;

    game_sequencer #(.COUNT_SECS(3), .PLAY_SECS(60)) dut (
        .clk(clk), .reset(reset), .key_code(key_code), .key_press(key_press),
        .tick_1s(tick_1s), .song_done(song_done), .mode_sel(mode_sel),
        .lcd_state(lcd_state), .game_run(game_run), .game_clear(game_clear),
        .countdown(countdown), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input string name, input logic [4:0] code,
                                 input logic press, input logic tick, input logic done,
                                 input int st, input int md, input int cd,
                                 input logic run, input logic lcd, input logic clr,
                                 input logic rst = 1'b1);
        step_t s;
        s.name = name; s.code = code; s.press = press; s.tick = tick;
        s.done = done; s.rst = rst;
        s.vec = {st[2:0], md[1:0], cd[3:0], run, lcd, clr};
        return s;
    endfunction

    // SELECT from MENU through the 3-second countdown into PLAY.
    function automatic void add_start(input int md);
        plan.push_back(mk("start_select", K_S, 1, 0, 0, 1, md, 3, 0, 1, 1));
        plan.push_back(mk("start_release", K_X, 0, 0, 0, 1, md, 3, 0, 1, 0));
        plan.push_back(mk("cd_2", K_X, 0, 1, 0, 1, md, 2, 0, 1, 0));
        plan.push_back(mk("cd_1", K_X, 0, 1, 0, 1, md, 1, 0, 1, 0));
        plan.push_back(mk("cd_0", K_X, 0, 1, 0, 1, md, 0, 0, 1, 0));
        plan.push_back(mk("play_entry", K_X, 0, 0, 0, 2, md, 0, 1, 1, 0));
    endfunction

    function automatic void add_play_ticks(input int n, input int md);
        for (int i = 0; i < n; i++) begin
            plan.push_back(mk("play_tick", K_X, 0, 1, 0, 2, md, 0, 1, 1, 0));
        end
    endfunction

    task automatic drive(input step_t s);
        reset     = s.rst;
        key_code  = s.code;
        key_press = s.press;
        tick_1s   = s.tick;
        song_done = s.done;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t e;
        reset = 1'b0; key_code = K_X; key_press = 1'b0; tick_1s = 1'b0; song_done = 1'b0;
        #2;
        sb.push_back(mk("reset_async", K_X, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        e = sb.pop_front();
        checks++;
        if (act !== e.vec) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, act, e.vec);
        end
        plan.push_back(mk("reset_idle0", K_X, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        plan.push_back(mk("reset_idle1", K_X, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (plan[i]) begin
            sb.push_back(plan[i]);
            drive(plan[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s step %0d: got %h, expected %h", e.name, i, act, e.vec);
            end
        end
        plan.delete();
    endtask

    task automatic test_mode_select();
        step_t e;
        plan.push_back(mk("right_0to1", K_R, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("release", K_R, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("right_1to2", K_R, 1, 0, 0, 0, 2, 0, 0, 0, 0));
        plan.push_back(mk("release", K_R, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        plan.push_back(mk("left_2to1", K_L, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("release", K_L, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("other_key", K_X, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("release", K_X, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("left_1to3", K_L, 1, 0, 0, 0, 3, 0, 0, 0, 0));
        plan.push_back(mk("release", K_L, 0, 0, 0, 0, 3, 0, 0, 0, 0));
        plan.push_back(mk("right_3to1", K_R, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("release", K_R, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("pause_in_menu", K_P, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("release", K_P, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("done_in_menu", K_X, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("tick_in_menu", K_X, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("select_start", K_S, 1, 0, 0, 1, 1, 3, 0, 1, 1));
        plan.push_back(mk("clear_one_cycle", K_S, 0, 0, 0, 1, 1, 3, 0, 1, 0));
        foreach (plan[i]) begin
            sb.push_back(plan[i]);
            drive(plan[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s step %0d: got %h, expected %h", e.name, i, act, e.vec);
            end
        end
        plan.delete();
    endtask

    task automatic test_countdown_play();
        step_t e;
        plan.push_back(mk("key_and_tick_cd", K_R, 1, 1, 0, 1, 1, 2, 0, 1, 0));
        plan.push_back(mk("release", K_R, 0, 0, 0, 1, 1, 2, 0, 1, 0));
        plan.push_back(mk("done_in_cd", K_X, 0, 0, 1, 1, 1, 2, 0, 1, 0));
        plan.push_back(mk("cd_1", K_X, 0, 1, 0, 1, 1, 1, 0, 1, 0));
        plan.push_back(mk("cd_0", K_X, 0, 1, 0, 1, 1, 0, 0, 1, 0));
        plan.push_back(mk("play_entry", K_X, 0, 0, 0, 2, 1, 0, 1, 1, 0));
        plan.push_back(mk("select_in_play", K_S, 1, 0, 0, 2, 1, 0, 1, 1, 0));
        plan.push_back(mk("release", K_S, 0, 0, 0, 2, 1, 0, 1, 1, 0));
        add_play_ticks(59, 1);
        plan.push_back(mk("tick_60_expiry", K_X, 0, 1, 0, 4, 1, 0, 0, 1, 0));
        plan.push_back(mk("done_in_result", K_X, 0, 0, 1, 4, 1, 0, 0, 1, 0));
        plan.push_back(mk("right_in_result", K_R, 1, 0, 0, 4, 1, 0, 0, 1, 0));
        plan.push_back(mk("release", K_R, 0, 0, 0, 4, 1, 0, 0, 1, 0));
        plan.push_back(mk("select_to_menu", K_S, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("release", K_S, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        foreach (plan[i]) begin
            sb.push_back(plan[i]);
            drive(plan[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s step %0d: got %h, expected %h", e.name, i, act, e.vec);
            end
        end
        plan.delete();
    endtask

    task automatic test_song_done_tick();
        step_t e;
        add_start(1);
        add_play_ticks(10, 1);
        plan.push_back(mk("done_and_tick", K_X, 0, 1, 1, 4, 1, 0, 0, 1, 0));
        plan.push_back(mk("result_hold0", K_X, 0, 0, 0, 4, 1, 0, 0, 1, 0));
        plan.push_back(mk("result_hold1", K_X, 0, 1, 0, 4, 1, 0, 0, 1, 0));
        plan.push_back(mk("select_to_menu", K_S, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("release", K_S, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        foreach (plan[i]) begin
            sb.push_back(plan[i]);
            drive(plan[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s step %0d: got %h, expected %h", e.name, i, act, e.vec);
            end
        end
        plan.delete();
    endtask

    task automatic test_held_select();
        step_t e;
        plan.push_back(mk("right_1to2", K_R, 1, 0, 0, 0, 2, 0, 0, 0, 0));
        plan.push_back(mk("release", K_R, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        plan.push_back(mk("held_select_first", K_S, 1, 0, 0, 1, 2, 3, 0, 1, 1));
        for (int i = 1; i < 100; i++) begin
            plan.push_back(mk("held_select", K_S, 1, 0, 0, 1, 2, 3, 0, 1, 0));
        end
        plan.push_back(mk("held_release", K_S, 0, 0, 0, 1, 2, 3, 0, 1, 0));
        foreach (plan[i]) begin
            sb.push_back(plan[i]);
            drive(plan[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s step %0d: got %h, expected %h", e.name, i, act, e.vec);
            end
        end
        plan.delete();
    endtask

    task automatic test_reset_mid_play();
        step_t e;
        plan.push_back(mk("cd_2", K_X, 0, 1, 0, 1, 2, 2, 0, 1, 0));
        plan.push_back(mk("cd_1", K_X, 0, 1, 0, 1, 2, 1, 0, 1, 0));
        plan.push_back(mk("cd_0", K_X, 0, 1, 0, 1, 2, 0, 0, 1, 0));
        plan.push_back(mk("play_entry", K_X, 0, 0, 0, 2, 2, 0, 1, 1, 0));
        add_play_ticks(30, 2);
        foreach (plan[i]) begin
            sb.push_back(plan[i]);
            drive(plan[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s step %0d: got %h, expected %h", e.name, i, act, e.vec);
            end
        end
        plan.delete();
        reset = 1'b0;
        key_code = K_R;
        key_press = 1'b1;
        #1;
        sb.push_back(mk("reset_mid_play", K_R, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        e = sb.pop_front();
        checks++;
        if (act !== e.vec) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, act, e.vec);
        end
        plan.push_back(mk("in_reset", K_R, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        plan.push_back(mk("in_reset", K_R, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        plan.push_back(mk("held_after_reset", K_R, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        plan.push_back(mk("held_after_reset", K_R, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        plan.push_back(mk("release", K_R, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        plan.push_back(mk("select_mode0", K_S, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        plan.push_back(mk("release", K_S, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        plan.push_back(mk("left_0to3", K_L, 1, 0, 0, 0, 3, 0, 0, 0, 0));
        plan.push_back(mk("release", K_L, 0, 0, 0, 0, 3, 0, 0, 0, 0));
        plan.push_back(mk("left_3to2", K_L, 1, 0, 0, 0, 2, 0, 0, 0, 0));
        plan.push_back(mk("release", K_L, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        plan.push_back(mk("left_2to1", K_L, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("release", K_L, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        foreach (plan[i]) begin
            sb.push_back(plan[i]);
            drive(plan[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s step %0d: got %h, expected %h", e.name, i, act, e.vec);
            end
        end
        plan.delete();
    endtask

    task automatic test_pause();
        step_t e;
        add_start(1);
        add_play_ticks(20, 1);
`ifdef GAME_SEQ_PAUSE_EN
        plan.push_back(mk("pause_enter", K_P, 1, 0, 0, 3, 1, 0, 0, 1, 0));
        plan.push_back(mk("release", K_P, 0, 0, 0, 3, 1, 0, 0, 1, 0));
        for (int i = 0; i < 5; i++) begin
            plan.push_back(mk("pause_tick", K_X, 0, 1, 0, 3, 1, 0, 0, 1, 0));
        end
        plan.push_back(mk("done_in_pause", K_X, 0, 0, 1, 3, 1, 0, 0, 1, 0));
        plan.push_back(mk("right_in_pause", K_R, 1, 0, 0, 3, 1, 0, 0, 1, 0));
        plan.push_back(mk("release", K_R, 0, 0, 0, 3, 1, 0, 0, 1, 0));
        plan.push_back(mk("pause_resume", K_P, 1, 0, 0, 2, 1, 0, 1, 1, 0));
        plan.push_back(mk("release", K_P, 0, 0, 0, 2, 1, 0, 1, 1, 0));
        add_play_ticks(39, 1);
        plan.push_back(mk("expiry_after_40", K_X, 0, 1, 0, 4, 1, 0, 0, 1, 0));
        plan.push_back(mk("select_to_menu", K_S, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("release", K_S, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        add_start(1);
        plan.push_back(mk("pause_enter2", K_P, 1, 0, 0, 3, 1, 0, 0, 1, 0));
        plan.push_back(mk("release", K_P, 0, 0, 0, 3, 1, 0, 0, 1, 0));
        plan.push_back(mk("select_in_pause", K_S, 1, 0, 0, 4, 1, 0, 0, 1, 0));
        plan.push_back(mk("release", K_S, 0, 0, 0, 4, 1, 0, 0, 1, 0));
`else
        plan.push_back(mk("pause_ignored", K_P, 1, 0, 0, 2, 1, 0, 1, 1, 0));
        plan.push_back(mk("release", K_P, 0, 0, 0, 2, 1, 0, 1, 1, 0));
        plan.push_back(mk("pause_with_tick", K_P, 1, 1, 0, 2, 1, 0, 1, 1, 0));
        plan.push_back(mk("release", K_P, 0, 0, 0, 2, 1, 0, 1, 1, 0));
        add_play_ticks(38, 1);
        plan.push_back(mk("expiry_after_40", K_X, 0, 1, 0, 4, 1, 0, 0, 1, 0));
        plan.push_back(mk("pause_in_result", K_P, 1, 0, 0, 4, 1, 0, 0, 1, 0));
        plan.push_back(mk("release", K_P, 0, 0, 0, 4, 1, 0, 0, 1, 0));
`endif
        plan.push_back(mk("select_to_menu", K_S, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        plan.push_back(mk("release", K_S, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        foreach (plan[i]) begin
            sb.push_back(plan[i]);
            drive(plan[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s step %0d: got %h, expected %h", e.name, i, act, e.vec);
            end
        end
        plan.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode_select();
        test_countdown_play();
        test_song_done_tick();
        test_held_select();
        test_reset_mid_play();
        test_pause();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
